data_space_map: RTL

Parametrised, registered data-space decoder for the AVR core. It maps a flat 16-bit data address onto the general-purpose register file, the standard I/O block, an optional extended I/O block and an internal synchronous SRAM. It presents a request/acknowledge handshake, so the core tolerates the SRAM's extra read cycle. It also adds out-of-range error reporting, and serves as the data-memory front end for the LD/ST and IN/OUT paths of the execute stage.

---
 rtl/data_space_map.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/data_space_map.sv
// data_space_map
// Registered data-space decoder for the AVR core. It maps a flat data
// address, or an I/O index for IN/OUT, onto the general-purpose registers,
// the standard I/O block, an optional extended I/O block and an internal
// synchronous SRAM. It uses a req/ready/ack handshake: most accesses ack one
// cycle after accept, and SRAM reads ack two cycles after accept.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req, we         access request (taken only while ready=1), 1 = write
//   io_only         addr is an I/O index (IN/OUT) rather than a data address
//   addr, wdata     address / I/O index and write data
//   reg_bus         register file contents, register i at [8i+7:8i]
//   io_bus          I/O contents, standard then extended, same packing
//   ready           a request can be accepted this cycle
//   ack, err        completion pulse; err marks an out-of-range access
//   rdata           read data, valid with ack for reads, held between acks
//   reg_we, reg_waddr, io_we, wdata_out
//                   single-cycle write strobes towards the register file / I/O
module data_space_map #(
  parameter int NUM_REGS   = 32,
  parameter int NUM_IO     = 64,
  parameter int EXT_IO     = 0,
  parameter int SRAM_DEPTH = 2048,
  parameter int ADDR_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic                           we,
  input  logic                           io_only,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [7:0]                     wdata,
  input  logic [NUM_REGS*8-1:0]          reg_bus,
  input  logic [(NUM_IO+EXT_IO)*8-1:0]   io_bus,
  output logic                           ready,
  output logic                           ack,
  output logic [7:0]                     rdata,
  output logic                           err,
  output logic                           reg_we,
  output logic [4:0]                     reg_waddr,
  output logic [NUM_IO+EXT_IO-1:0]       io_we,
  output logic [7:0]                     wdata_out
);

  localparam int IO_TOTAL  = NUM_IO + EXT_IO;
  localparam int SRAM_BASE = NUM_REGS + IO_TOTAL;
  localparam int SRAM_AW   = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1;
  localparam int REG_SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int IO_SEL_W  = (IO_TOTAL > 1) ? $clog2(IO_TOTAL) : 1;

  // Region limits carry one extra bit so a region ending exactly at
  // 2**ADDR_W does not wrap to zero in the compare.
  localparam logic [ADDR_W:0] STD_IO_END = (ADDR_W+1)'(NUM_IO);
  localparam logic [ADDR_W:0] REG_END    = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] IO_END     = (ADDR_W+1)'(SRAM_BASE);
  localparam logic [ADDR_W:0] SRAM_END   = (ADDR_W+1)'(SRAM_BASE + SRAM_DEPTH);

  typedef enum logic [0:0] {IDLE, SRAM_RD} state_t;
  typedef enum logic [1:0] {T_REG, T_IO, T_SRAM, T_OOR} target_t;

  state_t  state, next_state;
  target_t target;

  logic [ADDR_W:0]    addr_x;
  logic [REG_SEL_W-1:0] reg_sel;
  logic [IO_SEL_W-1:0]  io_sel;
  logic [SRAM_AW-1:0]   sram_idx;
  logic               accept;
  logic               sram_we;
  logic               sram_re;
  logic [7:0]         sram_q;
  logic [7:0]         mem [SRAM_DEPTH];

  logic [7:0]         reg_bytes [NUM_REGS];
  logic [7:0]         io_bytes  [IO_TOTAL];

  logic               ack_d;
  logic               err_d;
  logic [7:0]         rdata_d;
  logic               reg_we_d;
  logic [4:0]         reg_waddr_d;
  logic [IO_TOTAL-1:0] io_we_d;
  logic [7:0]         wdata_out_d;

  assign ready  = (state == IDLE);
  // A request coinciding with reset is dropped, including any SRAM write.
  assign accept = req && ready && !rst;
  assign addr_x = {1'b0, addr};

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) reg_bytes[i] = reg_bus[8*i +: 8];
    for (int i = 0; i < IO_TOTAL; i++) io_bytes[i] = io_bus[8*i +: 8];
  end

  // Region decode. Offsets are taken at full address width; the narrow
  // selects are only meaningful once the matching range check has passed.
  always_comb begin
    target = T_OOR;
    if (io_only) begin
      if (addr_x < STD_IO_END) target = T_IO;
    end else if (addr_x < REG_END) begin
      target = T_REG;
    end else if (addr_x < IO_END) begin
      target = T_IO;
    end else if (addr_x < SRAM_END) begin
      target = T_SRAM;
    end
  end

  assign reg_sel  = REG_SEL_W'(addr);
  assign io_sel   = IO_SEL_W'(io_only ? addr : addr - ADDR_W'(NUM_REGS));
  assign sram_idx = SRAM_AW'(addr - ADDR_W'(SRAM_BASE));

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch; held values come from the flops.
  always_comb begin
    next_state  = state;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    reg_we_d    = 1'b0;
    io_we_d     = '0;
    rdata_d     = rdata;
    reg_waddr_d = reg_waddr;
    wdata_out_d = wdata_out;
    sram_we     = 1'b0;
    sram_re     = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (target)
            T_REG: begin
              ack_d = 1'b1;
              if (we) begin
                reg_we_d    = 1'b1;
                reg_waddr_d = 5'(addr);
                wdata_out_d = wdata;
              end else begin
                rdata_d = reg_bytes[reg_sel];
              end
            end
            T_IO: begin
              ack_d = 1'b1;
              if (we) begin
                io_we_d     = IO_TOTAL'(1) << io_sel;
                wdata_out_d = wdata;
              end else begin
                rdata_d = io_bytes[io_sel];
              end
            end
            T_SRAM: begin
              if (we) begin
                sram_we = 1'b1;
                ack_d   = 1'b1;
              end else begin
                sram_re    = 1'b1;
                next_state = SRAM_RD;
              end
            end
            T_OOR: begin
              ack_d   = 1'b1;
              err_d   = 1'b1;
              rdata_d = 8'h00;
            end
          endcase
        end
      end
      SRAM_RD: begin
        next_state = IDLE;
        ack_d      = 1'b1;
        rdata_d    = sram_q;
      end
    endcase
  end

  // NOTE: state and outputs are flops, so they use non-blocking assignments
  // only; the combinational block above uses blocking ones.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= 8'h00;
      reg_we    <= 1'b0;
      reg_waddr <= 5'd0;
      io_we     <= '0;
      wdata_out <= 8'h00;
    end else begin
      ack       <= ack_d;
      err       <= err_d;
      rdata     <= rdata_d;
      reg_we    <= reg_we_d;
      reg_waddr <= reg_waddr_d;
      io_we     <= io_we_d;
      wdata_out <= wdata_out_d;
    end
  end

  // NOTE: the SRAM array and its read register have no reset so the array
  // maps onto a plain synchronous RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (sram_we) mem[sram_idx] <= wdata;
    if (sram_re) sram_q <= mem[sram_idx];
  end

endmodule
